fp_op_initiator: RTL and testbench

FP_OP_INITIATOR -- requirements
Module: fp_op_initiator

---
 rtl/fp_op_initiator.sv | 144 ++++++++++++++
 tb/tb_fp_op_initiator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_op_initiator.sv
// Drives one operation at a time through a strobe/ack floating-point unit.
// Each job has a cycle budget; a job that exceeds it completes with a NaN flagged as a timeout.
module fp_op_initiator #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_a,
    input  logic [31:0] job_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_z,
    output logic        res_timeout,
    output logic [31:0] input_a,
    output logic        input_a_stb,
    input  logic        input_a_ack,
    output logic [31:0] input_b,
    output logic        input_b_stb,
    input  logic        input_b_ack,
    input  logic [31:0] output_z,
    input  logic        output_z_stb,
    output logic        output_z_ack,
    output logic [15:0] job_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT_Z = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      ABORT_Z  = 32'h7FC0_0000;

    state_t            state_reg, state_next;
    logic [31:0]       a_reg, a_next;
    logic [31:0]       b_reg, b_next;
    logic [31:0]       z_reg, z_next;
    logic              timeout_reg, timeout_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              z_ack_reg, z_ack_next;
    logic [15:0]       job_count_reg, job_count_next;
    logic              do_abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            z_reg         <= '0;
            timeout_reg   <= 1'b0;
            cnt_reg       <= '0;
            z_ack_reg     <= 1'b0;
            job_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            z_reg         <= z_next;
            timeout_reg   <= timeout_next;
            cnt_reg       <= cnt_next;
            z_ack_reg     <= z_ack_next;
            job_count_reg <= job_count_next;
        end
    end

    // The awaited handshake is tested before the budget, so a handshake on the last allowed cycle wins.
    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        z_next         = z_reg;
        timeout_next   = timeout_reg;
        cnt_next       = cnt_reg;
        z_ack_next     = 1'b0;
        job_count_next = job_count_reg;
        do_abort       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (job_valid) begin
                    a_next       = job_a;
                    b_next       = job_b;
                    cnt_next     = '0;
                    timeout_next = 1'b0;
                    state_next   = SEND_A;
                end
            end
            SEND_A: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (input_a_ack)
                    state_next = SEND_B;
                else if (cnt_reg == CNT_LAST)
                    do_abort = 1'b1;
            end
            SEND_B: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (input_b_ack)
                    state_next = WAIT_Z;
                else if (cnt_reg == CNT_LAST)
                    do_abort = 1'b1;
            end
            WAIT_Z: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (output_z_stb) begin
                    z_next         = output_z;
                    z_ack_next     = 1'b1;
                    job_count_next = job_count_reg + 16'd1;
                    state_next     = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    do_abort = 1'b1;
                end
            end
            DONE: begin
                if (res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (do_abort) begin
            state_next   = DONE;
            timeout_next = 1'b1;
            z_next       = ABORT_Z;
        end
    end

    assign job_ready    = (state_reg == IDLE);
    assign res_valid    = (state_reg == DONE);
    assign res_z        = z_reg;
    assign res_timeout  = timeout_reg;
    assign input_a      = a_reg;
    assign input_a_stb  = (state_reg == SEND_A);
    assign input_b      = b_reg;
    assign input_b_stb  = (state_reg == SEND_B);
    assign output_z_ack = z_ack_reg;
    assign job_count    = job_count_reg;

endmodule

// File: tb/tb_fp_op_initiator.sv
// Bench for fp_op_initiator: a delay-programmable FP unit responder, a table of directed jobs,
// random jobs against a cycle-budget model, and hand sequences for reset, spurious strobes and wrap.
module tb_fp_op_initiator;

    localparam int T = 16;
    localparam logic [31:0] NAN_Z = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid, job_ready;
    logic [31:0] job_a, job_b;
    logic        res_valid, res_ready;
    logic [31:0] res_z;
    logic        res_timeout;
    logic [31:0] input_a, input_b;
    logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb, output_z_ack;
    logic [15:0] job_count;

    fp_op_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_a(job_a), .job_b(job_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_timeout(res_timeout),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
        .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
        .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
        .job_count(job_count)
    );

    always #5 clk = ~clk;

    // Responder: acks each strobe after a programmable number of cycles, returns z after another.
    int          a_delay, b_delay, z_delay;
    int          a_cnt, b_cnt, z_cnt;
    logic        z_pend, spur_z;
    logic [31:0] z_val;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_cnt  <= 0;
            b_cnt  <= 0;
            z_cnt  <= 0;
            z_pend <= 1'b0;
        end else begin
            a_cnt <= input_a_stb ? a_cnt + 1 : 0;
            b_cnt <= input_b_stb ? b_cnt + 1 : 0;
            if (input_b_stb && input_b_ack) begin
                z_pend <= 1'b1;
                z_cnt  <= 0;
            end else if (output_z_ack || res_valid) begin
                z_pend <= 1'b0;
            end else if (z_pend) begin
                z_cnt <= z_cnt + 1;
            end
        end
    end

    assign input_a_ack  = input_a_stb && (a_cnt == a_delay);
    assign input_b_ack  = input_b_stb && (b_cnt == b_delay);
    assign output_z_stb = spur_z || (z_pend && (z_cnt >= z_delay));
    assign output_z     = z_val;

    // Per-job observation counters, sampled on the falling edge.
    int          a_cyc, b_cyc, zack_cyc, overlap, unstable;
    logic [31:0] cur_a, cur_b;

    always @(negedge clk) begin
        if (input_a_stb) begin
            a_cyc++;
            if (input_a !== cur_a) unstable++;
        end
        if (input_b_stb) begin
            b_cyc++;
            if (input_b !== cur_b) unstable++;
        end
        if (output_z_ack) zack_cyc++;
        if (input_a_stb && input_b_stb) overlap++;
    end

    int          total = 0;
    int          bad   = 0;
    logic [15:0] model_count = 16'd0;
    int          job_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: handshake k of the job lands on busy cycle idx (0 = SEND_A entry); it
    // succeeds only if idx <= T-1, otherwise the job ends after exactly T busy cycles.
    function automatic int model_busy(input int ad, input int bd, input int zd);
        int idx;
        idx = ad + bd + zd + 2;
        return (idx > T - 1) ? T : idx + 1;
    endfunction

    function automatic logic model_to(input int ad, input int bd, input int zd);
        return (ad + bd + zd + 2) > (T - 1);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                           input int ad, input int bd, input int zd, input int rw,
                           input logic [31:0] exp_z, input logic exp_to);
        int   lat, exp_lat, waited;
        logic stable_ok, ready_low;
        logic [31:0] held_z;
        waited = 0;
        while (!job_ready && waited < 50) begin
            step();
            waited++;
        end
        a_delay = ad; b_delay = bd; z_delay = zd; z_val = z;
        cur_a = a; cur_b = b;
        a_cyc = 0; b_cyc = 0; zack_cyc = 0; overlap = 0; unstable = 0;
        job_valid = 1'b1; job_a = a; job_b = b;
        lat = 0;
        do begin
            step();
            job_valid = 1'b0;
            lat++;
        end while (!res_valid && lat < 200);
        exp_lat = model_busy(ad, bd, zd) + 1;
        if (!exp_to) model_count = model_count + 16'd1;
        check("latency", lat, exp_lat);
        check("res_z", res_z, exp_z);
        check("res_timeout", {31'd0, res_timeout}, {31'd0, exp_to});
        check("job_count", {16'd0, job_count}, {16'd0, model_count});
        check("z_ack_cycles", zack_cyc, exp_to ? 0 : 1);
        check("strobe_overlap", overlap, 0);
        check("operand_stable", unstable, 0);
        if (!exp_to) begin
            check("a_stb_cycles", a_cyc, ad + 1);
            check("b_stb_cycles", b_cyc, bd + 1);
        end
        stable_ok = 1'b1; ready_low = 1'b1; held_z = res_z;
        for (int i = 0; i < rw; i++) begin
            step();
            if (!res_valid || res_z !== held_z) stable_ok = 1'b0;
            if (job_ready) ready_low = 1'b0;
        end
        check("done_hold", {31'd0, stable_ok}, 32'd1);
        check("done_not_ready", {31'd0, ready_low}, 32'd1);
        res_ready = 1'b1;
        job_valid = 1'b1;
        step();
        res_ready = 1'b0;
        job_valid = 1'b0;
        check("release_valid", {31'd0, res_valid}, 32'd0);
        check("release_idle", {31'd0, job_ready}, 32'd1);
        $display("job %0d a=%h b=%h delays=%0d/%0d/%0d lat=%0d z=%h to=%0d count=%0d",
                 job_no, a, b, ad, bd, zd, lat, res_z, res_timeout, job_count);
        job_no++;
    endtask

    typedef struct {
        logic [31:0] a, b, z;
        int          ad, bd, zd, rw;
        logic [31:0] exp_z;
        logic        exp_to;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          ad, bd, zd, waited;
        logic [31:0] ra, rb, rz;
        logic        saw_valid;

        vecs[0] = '{32'h41c80000, 32'h40000000, 32'h41d80000, 1, 1, 8, 0, 32'h41d80000, 1'b0};
        vecs[1] = '{32'h3f800000, 32'h40000000, 32'h40400000, 0, 0, 0, 0, 32'h40400000, 1'b0};
        vecs[2] = '{32'h40a00000, 32'h40400000, 32'h12345678, 1, 1, 255, 0, NAN_Z, 1'b1};
        vecs[3] = '{32'h3f000000, 32'h3e800000, 32'h3f400000, 0, 0, 13, 1, 32'h3f400000, 1'b0};
        vecs[4] = '{32'h3f000000, 32'h3e800000, 32'h3f400000, 0, 0, 14, 1, NAN_Z, 1'b1};
        vecs[5] = '{32'hc1200000, 32'h41200000, 32'h00000000, 20, 0, 0, 2, NAN_Z, 1'b1};
        vecs[6] = '{32'hc1200000, 32'h41200000, 32'h00000000, 0, 20, 0, 0, NAN_Z, 1'b1};
        vecs[7] = '{32'h42280000, 32'h3f800000, 32'h42240000, 0, 0, 0, 20, 32'h42240000, 1'b0};
        vecs[8] = '{32'h40490fdb, 32'h402df854, 32'h40c0e2f1, 13, 0, 0, 0, 32'h40c0e2f1, 1'b0};

        rst = 1'b0; job_valid = 1'b0; res_ready = 1'b0; spur_z = 1'b0;
        job_a = '0; job_b = '0; a_delay = 0; b_delay = 0; z_delay = 0; z_val = '0;
        cur_a = '0; cur_b = '0;
        #2;
        check("reset_job_ready", {31'd0, job_ready}, 32'd1);
        check("reset_res_valid", {31'd0, res_valid}, 32'd0);
        check("reset_strobes", {30'd0, input_a_stb, input_b_stb}, 32'd0);
        check("reset_res_z", res_z, 32'd0);
        check("reset_job_count", {16'd0, job_count}, 32'd0);
        repeat (3) step();
        rst = 1'b1;
        step();

        foreach (vecs[i])
            run_job(vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].ad, vecs[i].bd, vecs[i].zd,
                    vecs[i].rw, vecs[i].exp_z, vecs[i].exp_to);

        for (int n = 0; n < 24; n++) begin
            ad = $urandom_range(0, 6);
            bd = $urandom_range(0, 6);
            zd = ($urandom_range(0, 7) == 7) ? 255 : $urandom_range(0, 6);
            ra = $urandom; rb = $urandom; rz = $urandom;
            run_job(ra, rb, rz, ad, bd, zd, $urandom_range(0, 3),
                    model_to(ad, bd, zd) ? NAN_Z : rz, model_to(ad, bd, zd));
        end

        // Result strobes while idle must be ignored.
        spur_z = 1'b1; z_val = 32'hdeadbeef; zack_cyc = 0;
        repeat (5) step();
        spur_z = 1'b0;
        step();
        check("spurious_ack", zack_cyc, 0);
        check("spurious_count", {16'd0, job_count}, {16'd0, model_count});
        $display("spurious z strobe: acks=%0d count=%0d", zack_cyc, job_count);

        // Reset while operand B is being offered abandons the job.
        a_delay = 0; b_delay = 30; z_delay = 0;
        job_valid = 1'b1; job_a = 32'h11111111; job_b = 32'h22222222;
        step();
        job_valid = 1'b0;
        waited = 0;
        while (!input_b_stb && waited < 20) begin
            step();
            waited++;
        end
        check("reach_send_b", {31'd0, input_b_stb}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, job_ready}, 32'd1);
        check("mid_rst_outputs", {28'd0, res_valid, res_timeout, input_b_stb, output_z_ack}, 32'd0);
        check("mid_rst_input_a", input_a, 32'd0);
        check("mid_rst_input_b", input_b, 32'd0);
        check("mid_rst_res_z", res_z, 32'd0);
        check("mid_rst_count", {16'd0, job_count}, 32'd0);
        model_count = 16'd0;
        step();
        rst = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (res_valid || input_a_stb || input_b_stb) saw_valid = 1'b1;
        end
        check("post_rst_quiet", {31'd0, saw_valid}, 32'd0);
        $display("reset mid-job: quiet=%0d count=%0d", !saw_valid, job_count);
        run_job(32'h3f800000, 32'h3f800000, 32'h40000000, 0, 0, 0, 0, 32'h40000000, 1'b0);

        // Completed-job counter wraps from 0xFFFF to 0x0000.
        force dut.job_count_reg = 16'hFFFE;
        step();
        release dut.job_count_reg;
        model_count = 16'hFFFE;
        run_job(32'h40000000, 32'h40000000, 32'h40800000, 0, 0, 0, 0, 32'h40800000, 1'b0);
        run_job(32'h40000000, 32'h40400000, 32'h40c00000, 0, 0, 0, 0, 32'h40c00000, 1'b0);
        check("wrap_zero", {16'd0, job_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
